// File: rtl/mips_prog_loader.sv
// Framed byte-stream loader for the MIPS32 core: assembles big-endian words,
// writes them from address 0, verifies an XOR checksum and releases the core.
module mips_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

    state_t              state_q, state_d;
    logic [7:0]          nhi_q, nhi_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     widx_q, widx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          xsum_q, xsum_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                accept;
    logic [15:0]         n16;
    logic [ADDR_W:0]     widx_inc;

    assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
    assign busy     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_run  = done;

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign accept   = in_valid && in_ready;
    assign n16      = {nhi_q, in_data};
    assign widx_inc = widx_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nhi_q       <= '0;
            n_q         <= '0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            xsum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            nhi_q       <= nhi_d;
            n_q         <= n_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            xsum_q      <= xsum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nhi_d       = nhi_q;
        n_d         = n_q;
        widx_d      = widx_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;
        xsum_d      = xsum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // restart wins over a byte offered in the same cycle
        if (restart) begin
            state_d = S_IDLE;
            nhi_d   = '0;
            n_d     = '0;
            widx_d  = '0;
            bcnt_d  = '0;
            asm_d   = '0;
            xsum_d  = '0;
        end else if (accept) begin
            xsum_d = xsum_q ^ in_data;
            case (state_q)
                S_IDLE: begin
                    nhi_d   = in_data;
                    state_d = S_HDR;
                end
                S_HDR: begin
                    n_d    = (ADDR_W+1)'(n16);
                    widx_d = '0;
                    bcnt_d = '0;
                    if ({1'b0, n16} > MAX_N) begin
                        state_d = S_ERR;
                    end else if (n16 == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    asm_d  = {asm_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[ADDR_W-1:0];
                        mem_wdata_d = {asm_q, in_data};
                        widx_d      = widx_inc;
                        if (widx_inc == n_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    // running XOR already covers every earlier frame byte
                    state_d = (xsum_q == in_data) ? S_DONE : S_ERR;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Byte-stream program loader sitting directly upstream of the two-phase pipelined MIPS32 core. It receives a framed byte stream, assembles big-endian 32-bit instruction words, and writes them into the core's unified memory starting at word 0. It verifies an XOR checksum and then asserts `cpu_run`, which releases the core from halt with PC = 0. It replaces bench-side hierarchical preloading of `Mem[]`.

## Interface
- `ADDR_W`, 10: memory word-address width.
- `MEM_WORDS`, 1024: largest legal word count; must be ≤ 2^ADDR_W.

- `clk1`  in  1  loader clock; same net as the core's clk1.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `restart`  in  1  synchronous pulse: abort or finish, return to IDLE.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  load succeeded; sticky.
- `err`  out  1  load failed; sticky.
- `cpu_run`  out  1  core release; equals `done`.

## Operation
- Frame layout, in order:
  - N_hi, N_lo: 16-bit big-endian word count.
  - 4·N data bytes, MSB of each word first.
  - 1 checksum byte = XOR of every preceding frame byte, header included.
- A byte is accepted only on a clk1 rising edge with `in_valid && in_ready`. Gaps in `in_valid` stall the frame without penalty.
- States and transitions:
  - IDLE: accept N_hi → HDR.
  - HDR: accept N_lo → check N. If N > MEM_WORDS → ERR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register; a 2-bit byte counter tracks position. On the 4th byte, issue a write and increment the word index. After word N → CSUM.
  - CSUM: accept checksum byte. Match → DONE; mismatch → ERR.
  - DONE / ERR: terminal; `in_ready` = 0. `restart` → IDLE.
- Output levels by state:
  - `in_ready` = 1 in IDLE, HDR, DATA, CSUM; 0 in DONE, ERR.
  - `busy` = 1 in HDR, DATA, CSUM.
- Word index is ADDR_W+1 bits wide; N is compared unsigned against MEM_WORDS. Word N−1 lands at address N−1, so addresses never wrap.
- `restart` has priority over byte acceptance in any state. It clears the counters, running XOR, `done`, `err` and `cpu_run`. Memory words already written stay written.
- Reset mid-frame: all state is cleared asynchronously and a write in flight is dropped (`mem_we` → 0 immediately).

## Timing
- Reset values:
  - `in_ready` = 1 (state IDLE).
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `busy` = 0, `done` = 0, `err` = 0, `cpu_run` = 0.
- Throughput: one byte per cycle sustained; `in_ready` is never deasserted mid-frame.
- Write timing: `mem_we`, `mem_addr` and `mem_wdata` are registered. The write appears in the cycle after the 4th byte of a word is accepted and `mem_we` is high for exactly one cycle. Back-to-back words give a write every 4 cycles.
- Completion: `done`/`cpu_run` (or `err`) rise in the cycle after the checksum byte is accepted. For N ≥ 1, the last `mem_we` pulse precedes `cpu_run` by at least one cycle.
- Oversize N: `err` rises in the cycle after N_lo is accepted; no `mem_we` pulse occurs.
- `cpu_run` falls in the cycle after a `restart` is sampled.

## Test plan
- Load N=2 (frame 00 02 28 01 00 78 FC 00 00 00, checksum AF), streamed with no gaps → `mem_we` pulses writing addr 0 = 0x28010078 and addr 1 = 0xFC000000; `done` = `cpu_run` = 1 one cycle after AF is accepted; `err` = 0.
- Same frame with random 0–3 cycle `in_valid` gaps → identical writes and final state; no byte dropped or duplicated.
- Same frame with checksum AE → both words written; `err` = 1, `done` = 0, `cpu_run` = 0, `in_ready` = 0; then `restart` → IDLE, `in_ready` = 1, `err` = 0.
- Frame 00 00 00 → no `mem_we` pulse; `done` = 1 after the third byte.
- Header 04 01 (N=1025) with default MEM_WORDS → `err` = 1 one cycle after N_lo; no writes; further bytes are refused.
- Load the 8-word lw/sw program, pulse `rst_n` low after word 3, then reload the full frame → after the reset all outputs return to reset values and `mem_we` drops at once; the reload writes all 8 words; the core then runs and leaves Mem[121] = 130 with Mem[120] preset to 85.
